// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One bit per cycle over sign-stripped magnitudes; the sign is fixed up in a final cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    input  logic             hilo_read_i,
    input  logic [1:0]       hilo_we_i,
    input  logic [WIDTH-1:0] hilo_wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb, hi, lo;
    logic               is_div, neg_q, neg_r, done;

    logic               accept, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_cand;
    logic [WIDTH-1:0]   div_diff;
    logic               div_take;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    always_comb begin
        accept = (state == IDLE) && start_i && !flush_i;
        a_neg  = !op_i[0] && data1_i[WIDTH-1];
        b_neg  = !op_i[0] && data2_i[WIDTH-1];
        mag_a  = a_neg ? -data1_i : data1_i;
        mag_b  = b_neg ? -data2_i : data2_i;
    end

    // Divide-by-zero yields all-ones quotient magnitude, so its sign flip is suppressed.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_cand = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_take = div_cand >= {1'b0, opb};
        div_diff = div_cand[WIDTH-1:0] - opb;
        if (is_div)
            acc_step = div_take ? {div_diff, acc[WIDTH-2:0], 1'b1}
                                : {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (flush_i) state_next = IDLE;
                     else if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX) && !flush_i;
            if (state == IDLE) begin
                if (hilo_we_i[1]) hi <= hilo_wdata_i;
                if (hilo_we_i[0]) lo <= hilo_wdata_i;
            end else if (state == FIX && !flush_i) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (accept) begin
                cnt    <= CW'(WIDTH);
                is_div <= op_i[1];
                neg_q  <= (a_neg ^ b_neg) && (!op_i[1] || (|data2_i));
                neg_r  <= a_neg;
                opb    <= op_i[1] ? mag_b : mag_a;
                acc    <= {{WIDTH{1'b0}}, (op_i[1] ? mag_a : mag_b)};
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                acc <= acc_step;
            end
        end
    end

    always_comb begin
        busy_o  = (state != IDLE);
        stall_o = busy_o && (start_i || hilo_read_i || (|hilo_we_i));
        done_o  = done;
        hi_o    = hi;
        lo_o    = lo;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit at WIDTH=32 and WIDTH=8,
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, hilo_read;
    logic [1:0]  op, hilo_we;
    logic [31:0] data1, data2, hilo_wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  data1_8, data2_8, hi8, lo8;
    logic        busy8, done8, stall8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .data1_i(data1), .data2_i(data2), .flush_i(flush),
        .hilo_read_i(hilo_read), .hilo_we_i(hilo_we), .hilo_wdata_i(hilo_wdata),
        .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done), .stall_o(stall)
    );

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .op_i(op8),
        .data1_i(data1_8), .data2_i(data2_8), .flush_i(1'b0),
        .hilo_read_i(1'b0), .hilo_we_i(2'b00), .hilo_wdata_i(8'h00),
        .hi_o(hi8), .lo_o(lo8), .busy_o(busy8), .done_o(done8), .stall_o(stall8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: w-bit operands, results from ordinary integer arithmetic.
    function automatic void model(input int w, input logic [1:0] mop,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint unsigned mw, p;
        longint sa, sb, q, r;
        mw = (64'd1 << w) - 64'd1;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        p  = 64'd0;
        case (mop)
            2'b00: p = longint'(sa * sb);
            2'b01: p = longint'(a) * longint'(b);
            default: ;
        endcase
        if (!mop[1]) begin
            mlo = 32'(p & mw);
            mhi = 32'((p >> w) & mw);
        end else if (b == 32'd0) begin
            mlo = 32'(mw);
            mhi = a;
        end else if (mop == 2'b10) begin
            q   = sa / sb;
            r   = sa % sb;
            mlo = 32'(q & longint'(mw));
            mhi = 32'(r & longint'(mw));
        end else begin
            mlo = a / b;
            mhi = a % b;
        end
    endfunction

    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; data1 = a; data2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait32(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        int lat, bcnt;
        model(32, o, a, b, ehi, elo);
        issue32(o, a, b);
        wait32(lat, bcnt);
        check({tag, ".latency"}, 64'(lat), 64'd33);
        check({tag, ".busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] ehi, elo;
        int lat;
        model(8, o, {24'd0, a}, {24'd0, b}, ehi, elo);
        op8 = o; data1_8 = a; data2_8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd9);
        check({tag, ".hi"}, {56'd0, hi8}, {56'd0, ehi[7:0]});
        check({tag, ".lo"}, {56'd0, lo8}, {56'd0, elo[7:0]});
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b, lo_prev, lo_before;
        int n, bad;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_read = 1'b0;
        op = 2'b00; hilo_we = 2'b00; data1 = '0; data2 = '0; hilo_wdata = '0;
        start8 = 1'b0; op8 = 2'b00; data1_8 = '0; data2_8 = '0;
        #1;
        check("reset.hi", {32'd0, hi}, 64'd0);
        check("reset.lo", {32'd0, lo}, 64'd0);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.stall", {63'd0, stall}, 64'd0);
        check("reset.hi8", {56'd0, hi8}, 64'd0);
        check("reset.busy8", {63'd0, busy8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run32("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max.hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
        check("multu_max.lo_const", {32'd0, lo}, 64'h0000_0001);

        // Each run issues in the previous done cycle, so these are back-to-back.
        run32("mult_neg", 2'b00, -32'sd3, 32'd7);
        check("mult_neg.lo_const", {32'd0, lo}, 64'hFFFF_FFEB);
        run32("div_neg", 2'b10, -32'sd7, 32'd2);
        check("div_neg.lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_neg.hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
        run32("divu_zero", 2'b11, 32'd7, 32'd0);
        check("divu_zero.lo_const", {32'd0, lo}, 64'hFFFF_FFFF);
        run32("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
        run32("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.lo_const", {32'd0, lo}, 64'h8000_0000);
        check("div_ovf.hi_const", {32'd0, hi}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 50));
                2:       b = -32'($urandom_range(1, 50));
                default: b = $urandom;
            endcase
            run32($sformatf("rand%0d", i), o, a, b);
        end

        issue32(2'b11, 32'd1000, 32'd7);
        hilo_read = 1'b1; hilo_we = 2'b01; hilo_wdata = 32'h0000_DEAD;
        lo_before = lo;
        bad = 0; n = 0;
        while (!done && n < 100) begin
            if (busy && (stall !== 1'b1 || lo !== lo_before)) bad++;
            @(posedge clk); #1;
            n++;
        end
        check("stall.busy_cycles_bad", 64'(bad), 64'd0);
        check("stall.latency", 64'(n), 64'd33);
        check("stall.done_cycle_stall", {63'd0, stall}, 64'd0);
        check("stall.lo_result", {32'd0, lo}, 64'd142);
        check("stall.hi_result", {32'd0, hi}, 64'd6);
        @(posedge clk); #1;
        check("stall.lo_mtlo", {32'd0, lo}, 64'h0000_DEAD);
        hilo_read = 1'b0; hilo_we = 2'b00;

        hilo_we = 2'b10; hilo_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        hilo_we = 2'b00;
        check("mthi.hi", {32'd0, hi}, 64'h0000_1234);
        lo_prev = lo;
        issue32(2'b01, 32'd5, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        check("flush.busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.busy_after", {63'd0, busy}, 64'd0);
        count_done(40, n);
        check("flush.no_done", 64'(n), 64'd0);
        check("flush.hi", {32'd0, hi}, 64'h0000_1234);
        check("flush.lo", {32'd0, lo}, {32'd0, lo_prev});
        flush = 1'b1;
        issue32(2'b01, 32'd5, 32'd6);
        flush = 1'b0;
        check("flush_idle.start_ignored", {63'd0, busy}, 64'd0);
        run32("after_flush", 2'b01, 32'd5, 32'd6);

        a = $urandom | 32'h0100_0000;
        issue32(2'b10, a, 32'd3);
        repeat (14) begin @(posedge clk); #1; end
        check("rst_mid.busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.hi", {32'd0, hi}, 64'd0);
        check("rst_mid.lo", {32'd0, lo}, 64'd0);
        check("rst_mid.busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, n);
        check("rst_mid.no_done", 64'(n), 64'd0);
        check("rst_mid.busy_idle", {63'd0, busy}, 64'd0);

        run8("w8_multu_max", 2'b01, 8'hFF, 8'hFF);
        check("w8_multu_max.hi_const", {56'd0, hi8}, 64'hFE);
        check("w8_multu_max.lo_const", {56'd0, lo8}, 64'h01);
        run8("w8_div_ovf", 2'b10, 8'h80, 8'hFF);
        run8("w8_div_zero", 2'b10, 8'hF9, 8'h00);
        for (int i = 0; i < 8; i++) begin
            run8($sformatf("w8_rand%0d", i), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the pipelined CPU's EX stage. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width, one bit per cycle. While an operation is in flight it raises a stall request so dependent or conflicting instructions are held in ID/EX. A pipeline flush cancels the operation in flight.

## Interface
- WIDTH, 32, operand width in bits; even, ≥ 4; HI and LO are each WIDTH bits
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  launch the operation in op_i with data1_i/data2_i (sampled only when idle)
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- data1_i  in  WIDTH  rs operand (multiplicand / dividend)
- data2_i  in  WIDTH  rt operand (multiplier / divisor)
- flush_i  in  1  cancel the operation in flight; suppress start_i this cycle
- hilo_read_i  in  1  an MFHI/MFLO in EX needs HI/LO this cycle
- hilo_we_i  in  2  bit1 writes HI, bit0 writes LO (MTHI/MTLO)
- hilo_wdata_i  in  WIDTH  data for hilo_we_i
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse; hi_o/lo_o updated this cycle
- stall_o  out  1  combinational: busy_o & (start_i | hilo_read_i | |hilo_we_i)

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i & !flush_i → RUN.
  - Latch op and operand magnitudes. Signed ops use absolute values, computed modulo 2^WIDTH; unsigned ops use the raw operands.
  - Latch the result signs: quotient/product negative iff operand signs differ (signed ops only); remainder sign = dividend sign.
  - Iteration counter loaded with WIDTH.
- RUN: one iteration per cycle; counter decrements; at 0 → FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division; quotient bits shift into the low half, partial remainder into the high half.
- FIX:
  - Apply sign correction (two's-complement negate where required).
  - Write HI and LO, pulse done_o, → IDLE.
- Results:
  - Multiply: {HI, LO} = full 2·WIDTH product.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: runs full latency; LO = all ones, HI = original dividend, for both DIV and DIVU.
- Signed overflow (MIN / −1): LO = MIN, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- flush_i:
  - In RUN or FIX: → IDLE at the next edge, no done_o, HI/LO unchanged.
  - In IDLE: any concurrent start_i is ignored.
- start_i while busy is ignored; stall_o holds the instruction in EX.
- hilo_we_i:
  - Takes effect at the edge only when not busy.
  - While busy it raises stall_o and is not applied.
  - In IDLE with simultaneous start_i: the write applies now; the operation's result overwrites it at completion.
- hilo_read_i while busy raises stall_o. hi_o/lo_o always show the committed registers, never intermediate values.

## Timing
- Reset (async, immediate): HI = 0, LO = 0, state IDLE, busy_o = 0, done_o = 0; stall_o = 0 follows from busy_o = 0.
- Start sampled at edge E0 → busy_o = 1 after E0 through E(WIDTH+1).
- After edge E(WIDTH+1): busy_o = 0, done_o = 1 for one cycle, new HI/LO visible.
- Latency is therefore WIDTH+1 cycles from accept to result, and is the same for every operation and operand value.
- A new start_i may be accepted in the done_o cycle; back-to-back operations have no dead cycle.
- Reset asserted mid-operation: abort immediately to reset values; no done_o after release.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; done_o exactly 33 edges after the start edge; busy_o high for 33 cycles.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; then DIV −7 / 2 issued in the done_o cycle → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 0x00000007. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI 0x1234 while idle → hi_o = 0x1234. Start MULTU 5 × 6, flush_i at cycle 10 → no done_o, HI/LO still 0x1234/previous, busy_o low next cycle. A new start is then accepted.
- hilo_read_i and hilo_we_i = 01 held high during an operation → stall_o = 1 every busy cycle, 0 in the done_o cycle; LO is not written until busy_o falls.
- rst_n_i pulsed low at cycle 15 of a DIV → hi_o = lo_o = 0, busy_o = 0 asynchronously; no done_o afterwards. Repeat with WIDTH = 8: MULTU 0xFF × 0xFF → HI = 0xFE, LO = 0x01 after 9 cycles.
